// File: rtl/fir_coef_loader.sv
// Byte-serial FP16 coefficient loader for the W4823 FIR: converts each coefficient to
// 17-bit FP16i and writes it through cin/caddr with a registered, setup/hold-framed cload.
module fir_coef_loader #(
    parameter int NCOEF   = 64,
    parameter int ADDR_W  = 6,
    parameter bit REVERSE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [16:0]       cin,
    output logic [ADDR_W-1:0] caddr,
    output logic              cload,
    output logic              busy,
    output logic              done,
    output logic              err_special
);

    typedef enum logic [2:0] {
        IDLE,
        RX_LO,
        RX_HI,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(NCOEF - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] k;
    logic [7:0]        lo_byte;
    logic [15:0]       h_word;
    logic [ADDR_W-1:0] addr_k;

    // FP16 -> FP16i: hidden bit made explicit, denormals rebased to exponent 1,
    // Inf/NaN saturated to the largest finite magnitude.
    function automatic logic [16:0] conv(input logic [15:0] h);
        logic       s;
        logic [4:0] e;
        logic [9:0] m;
        s = h[15];
        e = h[14:10];
        m = h[9:0];
        if (e == 5'd0) begin
            conv = (m == 10'd0) ? {s, 16'h0000} : {s, 5'd1, 1'b0, m};
        end else if (e == 5'd31) begin
            conv = {s, 5'd30, 11'h7FF};
        end else begin
            conv = {s, e, 1'b1, m};
        end
    endfunction

    assign h_word   = {in_data, lo_byte};
    assign addr_k   = REVERSE ? (K_LAST - k) : k;
    assign in_ready = (state == RX_LO) || (state == RX_HI);
    assign busy     = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)    state_next = RX_LO;
            RX_LO:   if (in_valid) state_next = RX_HI;
            RX_HI:   if (in_valid) state_next = SETUP;
            SETUP:                 state_next = STROBE;
            STROBE:                state_next = HOLD;
            HOLD:    state_next = (k == K_LAST) ? IDLE : RX_LO;
            default:               state_next = IDLE;
        endcase
    end

    // NOTE: all state here is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            lo_byte     <= '0;
            cin         <= '0;
            caddr       <= '0;
            cload       <= 1'b0;
            done        <= 1'b0;
            err_special <= 1'b0;
        end else begin
            state <= state_next;
            // cload drives the FIR's CMEM clock, so it comes straight off a flop.
            cload <= (state_next == STROBE);
            case (state)
                IDLE: begin
                    if (start) begin
                        k           <= '0;
                        done        <= 1'b0;
                        err_special <= 1'b0;
                    end
                end
                RX_LO: begin
                    if (in_valid) lo_byte <= in_data;
                end
                RX_HI: begin
                    if (in_valid) begin
                        cin   <= conv(h_word);
                        caddr <= addr_k;
                        if (h_word[14:10] == 5'd31) err_special <= 1'b1;
                    end
                end
                HOLD: begin
                    if (k == K_LAST) done <= 1'b1;
                    else             k    <= k + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader: conversion cases, cload framing, frame timing,
// forward/reverse addressing, input stalls, ignored mid-frame start and reset abort.
module tb_fir_coef_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;

    logic        in_ready,   in_ready_r;
    logic [16:0] cin,        cin_r;
    logic [5:0]  caddr,      caddr_r;
    logic        cload,      cload_r;
    logic        busy,       busy_r;
    logic        done,       done_r;
    logic        err_special, err_special_r;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [16:0] q_cin[$];
    logic [5:0]  q_addr[$];
    logic [5:0]  q_addr_r[$];

    fir_coef_loader #(.NCOEF(64), .ADDR_W(6), .REVERSE(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .cin(cin), .caddr(caddr), .cload(cload),
        .busy(busy), .done(done), .err_special(err_special)
    );

    fir_coef_loader #(.NCOEF(64), .ADDR_W(6), .REVERSE(1'b1)) dut_r (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_r), .cin(cin_r), .caddr(caddr_r), .cload(cload_r),
        .busy(busy_r), .done(done_r), .err_special(err_special_r)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe seen by the FIR side of both instances.
    always @(negedge clk) begin
        if (cload) begin
            q_cin.push_back(cin);
            q_addr.push_back(caddr);
        end
        if (cload_r) q_addr_r.push_back(caddr_r);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        int   n;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_data  = b;
        in_valid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 64) begin
            ok = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!ok) check("handshake_timeout", 32'(ok), 32'd1);
    endtask

    // Returns one cycle after the hi-byte handshake, i.e. in SETUP.
    task automatic send_coef(input logic [15:0] h, input int gap);
        send_byte(h[7:0], gap);
        send_byte(h[15:8], gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        check("done_wait", 32'(done), 32'd1);
    endtask

    initial begin
        int cyc_start;
        logic [31:0] exp_cin;

        rst = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_cin", 32'(cin), 32'd0);
        check("rst_caddr", 32'(caddr), 32'd0);
        check("rst_cload", 32'(cload), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_special), 32'd0);

        // Frame 1: directed conversions and cload framing.
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_in_ready", 32'(in_ready), 32'd1);

        send_coef(16'h3C00, 0);
        check("one_setup_cin", 32'(cin), 32'h07C00);
        check("one_setup_caddr", 32'(caddr), 32'd0);
        check("one_setup_cload", 32'(cload), 32'd0);
        check("one_setup_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("one_strobe_cload", 32'(cload), 32'd1);
        check("one_strobe_cin", 32'(cin), 32'h07C00);
        tick();
        check("one_hold_cload", 32'(cload), 32'd0);
        check("one_hold_cin", 32'(cin), 32'h07C00);
        check("one_hold_caddr", 32'(caddr), 32'd0);
        tick();
        check("one_next_in_ready", 32'(in_ready), 32'd1);

        send_coef(16'hC000, 0);
        check("neg2_cin", 32'(cin), 32'h18400);
        check("neg2_caddr", 32'(caddr), 32'd1);
        send_coef(16'h0001, 0);
        check("denorm_cin", 32'(cin), 32'h00801);
        check("denorm_caddr", 32'(caddr), 32'd2);
        send_coef(16'h0000, 0);
        check("zero_cin", 32'(cin), 32'h00000);
        check("zero_err", 32'(err_special), 32'd0);

        send_coef(16'h7C00, 0);
        check("inf_cin", 32'(cin), 32'h0F7FF);
        check("inf_err", 32'(err_special), 32'd1);
        send_coef(16'h3C05, 0);
        check("err_sticky", 32'(err_special), 32'd1);
        pulse_start();
        check("err_after_ignored_start", 32'(err_special), 32'd1);
        for (int k = 6; k < 64; k++) send_coef(16'h3C00 + 16'(k), 0);
        check("f1_done_before_hold", 32'(done), 32'd0);
        tick(); tick(); tick();
        check("f1_done", 32'(done), 32'd1);
        check("f1_busy", 32'(busy), 32'd0);
        check("f1_err_kept", 32'(err_special), 32'd1);
        check("f1_pulses", 32'(q_cin.size()), 32'd64);
        check("f1_addr63", 32'(q_addr[63]), 32'd63);

        // Frame 2: full input rate, frame timing, forward and reverse addresses.
        q_cin.delete(); q_addr.delete(); q_addr_r.delete();
        pulse_start();
        cyc_start = cyc;
        check("f2_err_cleared", 32'(err_special), 32'd0);
        check("f2_done_cleared", 32'(done), 32'd0);
        for (int k = 0; k < 64; k++) send_coef(16'h3C00 + 16'(k), 0);
        wait_done();
        check("f2_done_cycle", 32'(cyc - cyc_start + 1), 32'd321);
        check("f2_pulses", 32'(q_cin.size()), 32'd64);
        check("f2_pulses_r", 32'(q_addr_r.size()), 32'd64);
        for (int k = 0; k < 64 && k < q_cin.size() && k < q_addr_r.size(); k++) begin
            check($sformatf("f2_cin_%0d", k), 32'(q_cin[k]), 32'h07C00 + 32'(k));
            check($sformatf("f2_addr_%0d", k), 32'(q_addr[k]), 32'(k));
            check($sformatf("f2_addr_r_%0d", k), 32'(q_addr_r[k]), 32'(63 - k));
        end

        // Frame 3: random input gaps and a start pulse mid-frame.
        q_cin.delete(); q_addr.delete(); q_addr_r.delete();
        pulse_start();
        for (int k = 0; k < 64; k++) begin
            if (k == 30) begin
                tick(); tick(); tick();
                pulse_start();
                check("f3_busy_after_start", 32'(busy), 32'd1);
                check("f3_in_ready_after_start", 32'(in_ready), 32'd1);
            end
            send_coef(16'(k), int'($urandom_range(0, 3)));
            if (k == 63) check("f3_done_early", 32'(done), 32'd0);
        end
        wait_done();
        check("f3_err", 32'(err_special), 32'd0);
        check("f3_pulses", 32'(q_cin.size()), 32'd64);
        for (int k = 0; k < 64 && k < q_cin.size(); k++) begin
            exp_cin = (k == 0) ? 32'h0 : 32'h00800 + 32'(k);
            check($sformatf("f3_cin_%0d", k), 32'(q_cin[k]), exp_cin);
            check($sformatf("f3_addr_%0d", k), 32'(q_addr[k]), 32'(k));
        end

        // Frame 4: reset in STROBE of coefficient 10.
        pulse_start();
        for (int k = 0; k <= 10; k++) send_coef(16'h3C00 + 16'(k), 0);
        tick();
        check("f4_strobe_cload", 32'(cload), 32'd1);
        check("f4_strobe_caddr", 32'(caddr), 32'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("f4_rst_cload", 32'(cload), 32'd0);
        check("f4_rst_busy", 32'(busy), 32'd0);
        check("f4_rst_done", 32'(done), 32'd0);
        check("f4_rst_caddr", 32'(caddr), 32'd0);
        check("f4_rst_in_ready", 32'(in_ready), 32'd0);

        // Frame 5: restart writes from address 0 again.
        pulse_start();
        send_coef(16'h4000, 0);
        check("f5_cin", 32'(cin), 32'h08400);
        check("f5_caddr", 32'(caddr), 32'd0);
        check("f5_caddr_r", 32'(caddr_r), 32'd63);
        check("f5_cin_r", 32'(cin_r), 32'h08400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
